iot_stream_filter_p: RTL
========================

// Module: iot_stream_filter_p
// PURPOSE
//  Parametrised successor of the IoT data filter. Accepts records of NB words of W bits,
//  one word per cycle, MS word first, grouped NR records per group. Per fn_sel it reports
//  MAX, MIN, AVG, EXTRACT, EXCLUDE, PEAK_MAX or PEAK_MIN. Sits between the sensor byte
//  stream and the host result bus; adds peak tracking and a busy-driven flush slot.
// PARAMETERS
//  W       8                 word width (bits)
//  NB      16                words per record; record width RW = W*NB
//  NR      8                 records per group; power of two, >=2
//  EXT_LO  RW'h6FFF..F        EXTRACT lower bound (exclusive)
//  EXT_HI  RW'hAFFF..F        EXTRACT upper bound (exclusive)
//  EXC_LO  RW'h7FFF..F        EXCLUDE lower bound (exclusive)
//  EXC_HI  RW'hBFFF..F        EXCLUDE upper bound (exclusive)
// PORTS
//  clk      in   1        clock, rising edge
//  rst      in   1        synchronous, active-high reset
//  in_en    in   1        iot_in valid this cycle
//  iot_in   in   W        data word, MS word of record first
//  fn_sel   in   3        1 MAX,2 MIN,3 AVG,4 EXTRACT,5 EXCLUDE,6 PEAK_MAX,7 PEAK_MIN,0 none
//  busy     out  1        1 = input not accepted this cycle
//  valid    out  1        1-cycle pulse, iot_out holds a new result
//  iot_out  out  RW       result record
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset: busy=0, valid=0, iot_out=0,
//    word/record counters=0, accumulators=0, peak_valid=0, state=IDLE. Reset mid-record
//    discards all partial data.
//  - FSM: IDLE -(in_en)-> RECV; RECV -(group end, fn 1,2,3,6,7)-> FLUSH; FLUSH -> RECV
//    (in_en) else IDLE. Record end with fn 4/5 stays RECV. busy=1 only in FLUSH; a word
//    offered while busy=1 is dropped.
//  - fn_sel latched on first word of each group; mid-group changes ignored. Latched fn
//    differing from the previous group's clears peak_valid. fn 0: words consumed, no valid.
//  - in_en low mid-record: partial record discarded, word counter -> 0; record counter kept.
//  - Comparisons unsigned over full RW. MAX/MIN: strict, ties keep earlier record.
//  - AVG: sum width RW+log2(NR), no overflow; result = sum >> log2(NR) (floor).
//  - EXTRACT: EXT_LO < rec < EXT_HI. EXCLUDE: rec < EXC_LO or rec > EXC_HI. Boundaries
//    never pass. Qualifying record: iot_out=rec, valid=1 the cycle after its last word.
//  - fn 1/2/3: iot_out=group result, valid=1 in FLUSH cycle (2 cycles after last word).
//  - PEAK_MAX/MIN: group extreme compared with stored peak; if !peak_valid or strictly
//    beyond, peak updated, iot_out=peak, valid=1 in FLUSH; else no valid, iot_out holds.
//  - iot_out changes only together with valid=1; holds otherwise.
//  - Record counter wraps to 0 after NR records; back-to-back groups need no idle gap
//    beyond the FLUSH cycle.
// TESTING
//  - Defaults, fn=1, records 0x01..01,0x05..05,0x03..03,5x0x02..02 -> one valid, iot_out=0x05..05.
//  - fn=3, eight records all 0xFF..FF -> iot_out=0xFF..FF; records k=0..7 value k -> iot_out=3.
//  - fn=4, records 0x6FFF..F,0x7000..0,0xAFFF..F -> exactly one valid, iot_out=0x7000..0.
//  - fn=6, group maxima 0x10..,0x08..,0x20.. -> valid on groups 1 and 3 only; fn to 7 clears peak.
//  - in_en dropped after 9 words, then 16 fresh words -> record counted once, data is fresh words.
//  - Word offered during FLUSH (busy=1) ignored; rst mid-group -> valid=0, next group from zero.

Source files
------------

// File: rtl/iot_stream_filter_p.sv
// Parametrised IoT stream filter: assembles NB-word records (MS word first), groups them NR
// at a time and reports MAX / MIN / AVG / EXTRACT / EXCLUDE / PEAK_MAX / PEAK_MIN results.
module iot_stream_filter_p #(
    parameter int unsigned     W      = 8,
    parameter int unsigned     NB     = 16,
    parameter int unsigned     NR     = 8,
    parameter logic [W*NB-1:0] EXT_LO = {4'h6, {(W*NB-4){1'b1}}},
    parameter logic [W*NB-1:0] EXT_HI = {4'hA, {(W*NB-4){1'b1}}},
    parameter logic [W*NB-1:0] EXC_LO = {4'h7, {(W*NB-4){1'b1}}},
    parameter logic [W*NB-1:0] EXC_HI = {4'hB, {(W*NB-4){1'b1}}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_en,
    input  logic [W-1:0]    iot_in,
    input  logic [2:0]      fn_sel,
    output logic            busy,
    output logic            valid,
    output logic [W*NB-1:0] iot_out
);

    localparam int unsigned RW  = W * NB;
    localparam int unsigned LG  = $clog2(NR);
    localparam int unsigned WCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned SW  = RW + LG;

    localparam logic [2:0] FnMax     = 3'd1;
    localparam logic [2:0] FnMin     = 3'd2;
    localparam logic [2:0] FnAvg     = 3'd3;
    localparam logic [2:0] FnExtract = 3'd4;
    localparam logic [2:0] FnExclude = 3'd5;
    localparam logic [2:0] FnPeakMax = 3'd6;
    localparam logic [2:0] FnPeakMin = 3'd7;

    typedef enum logic [1:0] {StIdle, StRecv, StFlush} state_e;

    state_e state_q, state_d;

    logic [WCW-1:0] wcnt_q;
    logic [LG-1:0]  rcnt_q;
    logic [2:0]     fn_q;
    logic [RW-1:0]  shift_q;
    logic [RW-1:0]  ext_q;
    logic [SW-1:0]  sum_q;
    logic [RW-1:0]  peak_q;
    logic           peak_valid_q;
    logic           flush_pend_q;
    logic           res_valid_q;
    logic [RW-1:0]  res_q;

    logic           accept;
    logic           grp_start;
    logic           rec_done;
    logic           grp_first;
    logic           grp_last;
    logic           use_min;
    logic           is_group_fn;
    logic           is_peak_fn;
    logic           rec_pass;
    logic           ext_take;
    logic           peak_take;
    logic [RW-1:0]  rec_full;
    logic [RW-1:0]  ext_nxt;
    logic [RW-1:0]  grp_res;
    logic [SW-1:0]  sum_nxt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; FLUSH follows one cycle after the group's last record is absorbed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_en) state_d = StRecv;
            StRecv:  if (flush_pend_q) state_d = StFlush;
            StFlush: state_d = in_en ? StRecv : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: words are refused only while flushing
    always_comb begin
        busy   = (state_q == StFlush);
        accept = in_en && !busy;
    end

    // Record assembly and per-record decisions
    always_comb begin
        rec_full    = {shift_q[RW-W-1:0], iot_in};
        rec_done    = accept && (wcnt_q == WCW'(NB - 1));
        grp_start   = accept && (wcnt_q == '0) && (rcnt_q == '0);
        grp_first   = (rcnt_q == '0);
        grp_last    = (rcnt_q == LG'(NR - 1));
        use_min     = (fn_q == FnMin) || (fn_q == FnPeakMin);
        is_peak_fn  = (fn_q == FnPeakMax) || (fn_q == FnPeakMin);
        is_group_fn = (fn_q == FnMax) || (fn_q == FnMin) || (fn_q == FnAvg) || is_peak_fn;
        // Strict compare so ties keep the earlier record
        ext_take    = grp_first || (use_min ? (rec_full < ext_q) : (rec_full > ext_q));
        ext_nxt     = ext_take ? rec_full : ext_q;
        sum_nxt     = grp_first ? SW'(rec_full) : sum_q + SW'(rec_full);
        peak_take   = !peak_valid_q || (use_min ? (ext_nxt < peak_q) : (ext_nxt > peak_q));
        grp_res     = (fn_q == FnAvg) ? sum_nxt[SW-1:LG] : ext_nxt;
        rec_pass    = 1'b0;
        if (fn_q == FnExtract) begin
            rec_pass = (rec_full > EXT_LO) && (rec_full < EXT_HI);
        end else if (fn_q == FnExclude) begin
            rec_pass = (rec_full < EXC_LO) || (rec_full > EXC_HI);
        end
    end

    // Word/record counters, shift register and per-group function latch
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            fn_q    <= '0;
            shift_q <= '0;
        end else if (!in_en) begin
            // A gap mid-record abandons the partial record; stale bytes shift out later
            wcnt_q <= '0;
        end else if (accept) begin
            shift_q <= rec_full;
            wcnt_q  <= rec_done ? '0 : wcnt_q + 1'b1;
            if (grp_start) fn_q <= fn_sel;
            if (rec_done) rcnt_q <= grp_last ? '0 : rcnt_q + 1'b1;
        end
    end

    // Group accumulation, peak tracking and the result held for the FLUSH slot
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q        <= '0;
            sum_q        <= '0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
        end else begin
            flush_pend_q <= 1'b0;
            if (grp_start && (fn_sel != fn_q)) peak_valid_q <= 1'b0;
            if (rec_done) begin
                ext_q <= ext_nxt;
                sum_q <= sum_nxt;
                if (grp_last && is_group_fn) begin
                    flush_pend_q <= 1'b1;
                    res_q        <= grp_res;
                    res_valid_q  <= 1'b1;
                    if (is_peak_fn) begin
                        res_valid_q <= peak_take;
                        if (peak_take) begin
                            peak_q       <= ext_nxt;
                            peak_valid_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output register: iot_out moves only together with a valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            iot_out <= '0;
        end else if (flush_pend_q) begin
            valid <= res_valid_q;
            if (res_valid_q) iot_out <= res_q;
        end else if (rec_done && rec_pass) begin
            valid   <= 1'b1;
            iot_out <= rec_full;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule
